pim_cmd_issuer: RTL
===================

Name: pim_cmd_issuer

Overview:
- Initiator side of the PIM execution-unit command interface.
- Accepts float add/mul requests on a valid/ready channel and drives ALU_Command/data1/data2 using the zero-to-nonzero start-edge protocol.
- Waits for result_valid, captures the result and returns it on a valid/ready response channel.
- Bounded wait with a timeout error; sits between the PIM page controller and the execution unit.

Parameters:
- DATA_W, 32, operand/result width (IEEE-754 single).
- CMD_W, 5, ALU_Command width.
- ADD_CMD, 5'b10000, command code for float add.
- MUL_CMD, 5'b10010, command code for float multiply.
- TIMEOUT, 64, max WAIT cycles before error; legal range 2..65535.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when high with req_valid
- req_op  in  2  0=add, 1=mul, 2/3=illegal
- req_a  in  DATA_W  operand A
- req_b  in  DATA_W  operand B
- ALU_Command  out  CMD_W  command to exec unit
- data1  out  DATA_W  operand A to exec unit
- data2  out  DATA_W  operand B to exec unit
- result  in  DATA_W  exec result
- result_valid  in  1  exec result strobe
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_data  out  DATA_W  captured result (0 on error)
- rsp_err  out  1  1=timeout or illegal op
- busy  out  1  high in any state other than IDLE

Behaviour:
- One clock; reset is synchronous and active-high. All outputs registered except req_ready and busy, which decode state.
- Reset values: state=IDLE, ALU_Command=0, data1=data2=0, rsp_valid=0, rsp_data=0, rsp_err=0, wait counter=0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1; ALU_Command=0.
  - On req_valid: latch req_a into data1 and req_b into data2.
  - Legal op -> ISSUE.
  - Illegal op -> RESP with rsp_err=1, rsp_data=0; exec unit untouched.
- ISSUE (exactly 1 cycle):
  - ALU_Command = ADD_CMD or MUL_CMD; counter cleared; -> WAIT.
  - result_valid in this cycle is ignored.
- WAIT:
  - ALU_Command held at the issued code; data1/data2 held stable; counter increments each cycle.
  - result_valid=1 -> rsp_data<=result, rsp_err<=0, ALU_Command<=0, -> RESP.
  - Counter reaches TIMEOUT-1 without result_valid -> rsp_data<=0, rsp_err<=1, ALU_Command<=0, -> RESP.
  - result_valid in the timeout cycle: the result wins, not an error.
- RESP:
  - rsp_valid=1; ALU_Command=0; rsp_data/rsp_err stable until handshake.
  - rsp_ready=1 -> rsp_valid<=0, -> IDLE.
  - Backpressure holds indefinitely.
- Start-edge guarantee: ALU_Command is 0 for at least 2 cycles (RESP + IDLE accept) before every nonzero value, so the exec unit sees exactly one start per request.
- Latency: accept at cycle T; ALU_Command nonzero at T+1; exec result_valid at T+1+L; rsp_valid at T+2+L.
- result_valid in IDLE or RESP (including a late result after a timeout) is ignored; rsp_data is not modified.
- Reset mid-operation: return to IDLE next edge, ALU_Command=0, any pending response dropped.
- Throughput: one outstanding command; next accept no earlier than the cycle after the RESP handshake.

Optional Feature:
- Macro PIM_ISSUER_STATS_EN.
- Defined: adds three 16-bit saturating output counters, reset to 0:
  - stat_done: responses with rsp_err=0.
  - stat_timeout: timeout errors (illegal ops not counted).
  - stat_stray: result_valid seen outside WAIT.
- Undefined: ports and logic are absent; core behaviour is identical.

Test Plan:
- Add: req_op=0, a=0x3F800000, b=0x40000000; responder returns 0x40400000 after L=3 -> ALU_Command=5'b10000 at T+1 through T+4; rsp_valid at T+5, rsp_data=0x40400000, rsp_err=0.
- Mul with backpressure: op=1, a=0x40000000, b=0x40400000, result 0x40C00000; rsp_ready low 5 cycles -> rsp_valid/rsp_data held; ALU_Command=0 throughout RESP; next request accepted after handshake, with a zero gap of at least 2 cycles before its ALU_Command goes nonzero.
- Timeout: TIMEOUT=8, responder silent -> rsp_err=1, rsp_data=0 after 8 WAIT cycles; late result_valid 2 cycles later is ignored (stat_stray=1 when stats enabled).
- Illegal op: req_op=3 -> rsp_valid the next cycle, rsp_err=1; ALU_Command stays 0 throughout.
- Reset in WAIT: assert rst during WAIT -> next cycle state IDLE, ALU_Command=0, rsp_valid=0, req_ready=1.
- Back-to-back: 4 adds with rsp_ready tied high -> exactly 4 zero-to-nonzero edges on ALU_Command, 4 responses in order with correct data.

Source files
------------

// File: rtl/pim_cmd_issuer_if.sv
// pim_cmd_issuer_if: request/response channels plus the exec-unit command bus.
// slave = issuer side, master = page controller / exec unit / testbench side.
interface pim_cmd_issuer_if #(
  parameter int DATA_W = 32,
  parameter int CMD_W  = 5
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [CMD_W-1:0]  ALU_Command;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    input  result, result_valid, rsp_ready,
    output req_ready, ALU_Command, data1, data2,
    output rsp_valid, rsp_data, rsp_err, busy
  );

  modport master (
    output req_valid, req_op, req_a, req_b,
    output result, result_valid, rsp_ready,
    input  req_ready, ALU_Command, data1, data2,
    input  rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/pim_cmd_issuer.sv
// pim_cmd_issuer: issues float add/mul to the PIM exec unit with start-edge protocol.
// Optional PIM_ISSUER_STATS_EN adds saturating done/timeout/stray counters.
module pim_cmd_issuer #(
  parameter int             DATA_W  = 32,
  parameter int             CMD_W   = 5,
  parameter logic [CMD_W-1:0] ADD_CMD = 5'b10000,
  parameter logic [CMD_W-1:0] MUL_CMD = 5'b10010,
  parameter int             TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
`ifdef PIM_ISSUER_STATS_EN
  output logic [15:0] stat_done,
  output logic [15:0] stat_timeout,
  output logic [15:0] stat_stray,
`endif
  pim_cmd_issuer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t            r_state, w_state_n;
  logic [CMD_W-1:0]  r_cmd, w_cmd_n;
  logic [DATA_W-1:0] r_d1, w_d1_n;
  logic [DATA_W-1:0] r_d2, w_d2_n;
  logic [15:0]       r_cnt, w_cnt_n;
  logic              r_rv, w_rv_n;
  logic [DATA_W-1:0] r_rd, w_rd_n;
  logic              r_re, w_re_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cmd   <= '0;
      r_d1    <= '0;
      r_d2    <= '0;
      r_cnt   <= '0;
      r_rv    <= 1'b0;
      r_rd    <= '0;
      r_re    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cmd   <= w_cmd_n;
      r_d1    <= w_d1_n;
      r_d2    <= w_d2_n;
      r_cnt   <= w_cnt_n;
      r_rv    <= w_rv_n;
      r_rd    <= w_rd_n;
      r_re    <= w_re_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cmd_n   = r_cmd;
    w_d1_n    = r_d1;
    w_d2_n    = r_d2;
    w_cnt_n   = r_cnt;
    w_rv_n    = r_rv;
    w_rd_n    = r_rd;
    w_re_n    = r_re;
    unique case (r_state)
      IDLE: begin
        w_cmd_n = '0;
        if (bus.req_valid) begin
          w_d1_n = bus.req_a;
          w_d2_n = bus.req_b;
          if (bus.req_op[1]) begin
            // illegal op answers straight away; exec unit never sees it
            w_state_n = RESP;
            w_rv_n    = 1'b1;
            w_rd_n    = '0;
            w_re_n    = 1'b1;
          end else begin
            w_state_n = ISSUE;
            w_cmd_n   = bus.req_op[0] ? MUL_CMD : ADD_CMD;
          end
        end
      end
      ISSUE: begin
        w_cnt_n   = '0;
        w_state_n = WAIT;
      end
      WAIT: begin
        w_cnt_n = r_cnt + 16'd1;
        if (bus.result_valid) begin
          w_rd_n    = bus.result;
          w_re_n    = 1'b0;
          w_cmd_n   = '0;
          w_rv_n    = 1'b1;
          w_state_n = RESP;
        end else if (r_cnt == TO_LAST) begin
          w_rd_n    = '0;
          w_re_n    = 1'b1;
          w_cmd_n   = '0;
          w_rv_n    = 1'b1;
          w_state_n = RESP;
        end
      end
      RESP: begin
        w_cmd_n = '0;
        if (bus.rsp_ready) begin
          w_rv_n    = 1'b0;
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign bus.req_ready   = (r_state == IDLE);
  assign bus.busy        = (r_state != IDLE);
  assign bus.ALU_Command = r_cmd;
  assign bus.data1       = r_d1;
  assign bus.data2       = r_d2;
  assign bus.rsp_valid   = r_rv;
  assign bus.rsp_data    = r_rd;
  assign bus.rsp_err     = r_re;

`ifdef PIM_ISSUER_STATS_EN
  logic [15:0] r_st_done, r_st_to, r_st_stray;
  logic        w_in_wait;

  assign w_in_wait = (r_state == WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st_done  <= '0;
      r_st_to    <= '0;
      r_st_stray <= '0;
    end else begin
      if (w_in_wait && bus.result_valid && r_st_done != 16'hFFFF)
        r_st_done <= r_st_done + 16'd1;
      if (w_in_wait && !bus.result_valid && r_cnt == TO_LAST
          && r_st_to != 16'hFFFF)
        r_st_to <= r_st_to + 16'd1;
      if (!w_in_wait && bus.result_valid && r_st_stray != 16'hFFFF)
        r_st_stray <= r_st_stray + 16'd1;
    end
  end

  assign stat_done    = r_st_done;
  assign stat_timeout = r_st_to;
  assign stat_stray   = r_st_stray;
`endif

endmodule
